// File: rtl/engine_sequencer_if.sv
// Connection between the job sequencer and the shared PE engine.
// The sequencer drives registered operands; the engine returns result_out a fixed latency later.
interface engine_if #(
    parameter int DATA_WIDTH   = 16,
    parameter int WEIGHT_WIDTH = 4,
    parameter int RESULT_WIDTH = 16,
    parameter int PE_NUM       = 4
) ();
    logic [WEIGHT_WIDTH-1:0]        common_weight_in;
    logic [PE_NUM*4*DATA_WIDTH-1:0] data_in;
    logic [PE_NUM*RESULT_WIDTH-1:0] result_out;

    modport engine_master (
        output common_weight_in,
        output data_in,
        input  result_out
    );

    modport engine_slave (
        input  common_weight_in,
        input  data_in,
        output result_out
    );
endinterface

// File: rtl/engine_sequencer.sv
// Job-level controller: fetches weight/data beats, issues them to the PE engine,
// tracks them through the fixed engine latency and buffers results in a credit-protected FIFO.
module engine_sequencer #(
    parameter int DATA_WIDTH   = 16,
    parameter int WEIGHT_WIDTH = 4,
    parameter int RESULT_WIDTH = 16,
    parameter int PE_NUM       = 4,
    parameter int ENGINE_LAT   = 2,
    parameter int LEN_WIDTH    = 8,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           start,
    input  logic [LEN_WIDTH-1:0]           len,
    output logic                           busy,
    output logic                           done,
    input  logic                           w_valid,
    output logic                           w_ready,
    input  logic [WEIGHT_WIDTH-1:0]        w_data,
    input  logic                           d_valid,
    output logic                           d_ready,
    input  logic [PE_NUM*4*DATA_WIDTH-1:0] d_data,
    engine_if.engine_master                eng,
    output logic                           res_valid,
    input  logic                           res_ready,
    output logic [PE_NUM*RESULT_WIDTH-1:0] res_data,
    output logic                           res_last,
    output logic [1:0]                     dbg_state
);
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

    state_t                         state_q, state_d;
    logic [LEN_WIDTH-1:0]           len_q, len_d;
    logic [LEN_WIDTH-1:0]           issued_q, issued_d;
    logic [WEIGHT_WIDTH-1:0]        weight_q;
    logic [PE_NUM*4*DATA_WIDTH-1:0] data_q;
    logic [ENGINE_LAT:0]            vld_pipe_q, vld_pipe_d;
    logic [ENGINE_LAT:0]            last_pipe_q, last_pipe_d;
    logic [CNT_W-1:0]               in_flight_q, in_flight_d;
    logic [CNT_W-1:0]               fifo_cnt_q, fifo_cnt_d;
    logic [PTR_W-1:0]               rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]               wr_ptr_q, wr_ptr_d;
    logic [PE_NUM*RESULT_WIDTH-1:0] mem_q [FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0]          last_mem_q;

    logic             issue;
    logic             push;
    logic             pop;
    logic             credit_ok;
    logic [CNT_W:0]   outstanding;

    function automatic logic [PTR_W-1:0] nxt_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Outstanding work counts both in-flight beats and buffered results, from registered
    // counts only, so a result popped this cycle frees its slot one cycle later.
    assign outstanding = {1'b0, in_flight_q} + {1'b0, fifo_cnt_q};
    assign credit_ok   = outstanding < (CNT_W + 1)'(FIFO_DEPTH);

    assign push      = vld_pipe_q[ENGINE_LAT];
    assign res_valid = (fifo_cnt_q != '0);
    assign pop       = res_valid & res_ready;
    assign res_data  = mem_q[rd_ptr_q];
    assign res_last  = res_valid & last_mem_q[rd_ptr_q];

    assign eng.common_weight_in = weight_q;
    assign eng.data_in          = data_q;
    assign dbg_state            = state_q;

    // Stream handshake: a beat moves on valid&ready. w_ready and d_ready are raised together,
    // only in the cycle both streams are valid and the beat is actually issued.
    always_comb begin
        state_d  = state_q;
        len_d    = len_q;
        issued_d = issued_q;
        issue    = 1'b0;
        busy     = 1'b0;
        done     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (len == '0) begin
                        state_d = S_DONE;
                    end else begin
                        len_d    = len;
                        issued_d = '0;
                        state_d  = S_RUN;
                    end
                end
            end
            S_RUN: begin
                busy = 1'b1;
                if (w_valid && d_valid && credit_ok && (issued_q < len_q)) begin
                    issue    = 1'b1;
                    issued_d = issued_q + 1'b1;
                    if (issued_d == len_q) begin
                        state_d = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                busy = 1'b1;
                if ((in_flight_q == '0) && (fifo_cnt_q == '0)) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        w_ready = issue;
        d_ready = issue;
    end

    always_comb begin
        vld_pipe_d     = '0;
        last_pipe_d    = '0;
        vld_pipe_d[0]  = issue;
        last_pipe_d[0] = issue && (issued_q == len_q - 1'b1);
        for (int k = 1; k <= ENGINE_LAT; k++) begin
            vld_pipe_d[k]  = vld_pipe_q[k-1];
            last_pipe_d[k] = last_pipe_q[k-1];
        end
        in_flight_d = in_flight_q + CNT_W'(issue) - CNT_W'(push);
        fifo_cnt_d  = fifo_cnt_q + CNT_W'(push) - CNT_W'(pop);
        wr_ptr_d    = push ? nxt_ptr(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d    = pop ? nxt_ptr(rd_ptr_q) : rd_ptr_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            len_q       <= '0;
            issued_q    <= '0;
            weight_q    <= '0;
            data_q      <= '0;
            vld_pipe_q  <= '0;
            last_pipe_q <= '0;
            in_flight_q <= '0;
            fifo_cnt_q  <= '0;
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            last_mem_q  <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            issued_q    <= issued_d;
            vld_pipe_q  <= vld_pipe_d;
            last_pipe_q <= last_pipe_d;
            in_flight_q <= in_flight_d;
            fifo_cnt_q  <= fifo_cnt_d;
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            if (issue) begin
                weight_q <= w_data;
                data_q   <= d_data;
            end
            if (push) begin
                mem_q[wr_ptr_q]      <= eng.result_out;
                last_mem_q[wr_ptr_q] <= last_pipe_q[ENGINE_LAT];
            end
        end
    end

    // Credit gating makes a push into a full FIFO unreachable.
    fifo_no_overflow: assert property (@(posedge clk) disable iff (rst)
        !(push && (fifo_cnt_q == CNT_W'(FIFO_DEPTH))));

endmodule

// File: tb/tb_engine_sequencer.sv
// Randomized bench for engine_sequencer with a transaction-level reference model and a
// small behavioural PE engine on the engine_if slave side.
module tb_engine_sequencer;
    localparam int DW    = 16;
    localparam int WW    = 4;
    localparam int RW    = 16;
    localparam int PE    = 4;
    localparam int LAT   = 2;
    localparam int LW    = 8;
    localparam int DEPTH = 4;
    localparam int DV_W  = PE * 4 * DW;
    localparam int RV_W  = PE * RW;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            start = 1'b0;
    logic [LW-1:0]   len = '0;
    logic            busy, done;
    logic            w_valid, w_ready;
    logic [WW-1:0]   w_data;
    logic            d_valid, d_ready;
    logic [DV_W-1:0] d_data;
    logic            res_valid, res_ready, res_last;
    logic [RV_W-1:0] res_data;
    logic [1:0]      dbg_state;

    engine_if #(.DATA_WIDTH(DW), .WEIGHT_WIDTH(WW), .RESULT_WIDTH(RW), .PE_NUM(PE)) eng_bus ();

    engine_sequencer #(
        .DATA_WIDTH(DW), .WEIGHT_WIDTH(WW), .RESULT_WIDTH(RW), .PE_NUM(PE),
        .ENGINE_LAT(LAT), .LEN_WIDTH(LW), .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .len(len), .busy(busy), .done(done),
        .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data),
        .d_valid(d_valid), .d_ready(d_ready), .d_data(d_data),
        .eng(eng_bus),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_last(res_last),
        .dbg_state(dbg_state)
    );

    // clock
    always #5 clk = ~clk;

    // Behavioural engine: per PE, sum over four lanes of data*weight, truncated.
    function automatic logic [RV_W-1:0] eng_f(input logic [WW-1:0] w, input logic [DV_W-1:0] d);
        logic [RV_W-1:0] r;
        logic [RW-1:0]   acc;
        r = '0;
        for (int p = 0; p < PE; p++) begin
            acc = '0;
            for (int l = 0; l < 4; l++) begin
                acc = acc + RW'(d[(p*4+l)*DW +: DW] * RW'(w));
            end
            r[p*RW +: RW] = acc;
        end
        return r;
    endfunction

    logic [WW-1:0]   ew_p [LAT];
    logic [DV_W-1:0] ed_p [LAT];
    always @(posedge clk) begin
        ew_p[0] <= eng_bus.common_weight_in;
        ed_p[0] <= eng_bus.data_in;
        for (int k = 1; k < LAT; k++) begin
            ew_p[k] <= ew_p[k-1];
            ed_p[k] <= ed_p[k-1];
        end
    end
    assign eng_bus.result_out = eng_f(ew_p[LAT-1], ed_p[LAT-1]);

    // checking
    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    int hs_cnt = 0;

    task automatic check_eq(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (w_valid && w_ready && d_valid && d_ready) hs_cnt <= hs_cnt + 1;
    end

    // reference model: expected results in issue order with their earliest visible cycle
    logic [RV_W-1:0] exp_q [$];
    bit              exp_last_q [$];
    int              exp_avail_q [$];
    bit              job_active = 1'b0;
    bit              done_now = 1'b0;
    int              job_len = 0;
    int              iss = 0;
    int              pops = 0;
    logic [WW-1:0]   exp_w = '0;
    logic [DV_W-1:0] exp_d = '0;

    always @(negedge clk) begin : monitor
        bit rdy_e, vld_e, idle, drain_done, done_next;
        rdy_e = job_active && (iss < job_len) && w_valid && d_valid && ((iss - pops) < DEPTH);
        vld_e = (exp_q.size() > 0) && (exp_avail_q[0] <= cyc);
        check_eq("w_ready", w_ready, rdy_e);
        check_eq("d_ready", d_ready, rdy_e);
        check_eq("busy", busy, job_active);
        check_eq("done", done, done_now);
        check_eq("res_valid", res_valid, vld_e);
        check_eq("eng_weight", eng_bus.common_weight_in, exp_w);
        check_eq("eng_data", eng_bus.data_in, exp_d);
        if (res_valid && vld_e) begin
            check_eq("res_data", res_data, exp_q[0]);
            check_eq("res_last", res_last, exp_last_q[0]);
        end
        if (rst) begin
            exp_q.delete();
            exp_last_q.delete();
            exp_avail_q.delete();
            job_active = 1'b0;
            done_now   = 1'b0;
            job_len    = 0;
            iss        = 0;
            pops       = 0;
            exp_w      = '0;
            exp_d      = '0;
        end else begin
            idle       = !job_active && !done_now;
            drain_done = job_active && (iss == job_len) && (exp_q.size() == 0);
            done_next  = 1'b0;
            if (drain_done) begin
                job_active = 1'b0;
                done_next  = 1'b1;
            end
            if (rdy_e) begin
                exp_q.push_back(eng_f(w_data, d_data));
                exp_last_q.push_back(iss == job_len - 1);
                exp_avail_q.push_back(cyc + LAT + 2);
                exp_w = w_data;
                exp_d = d_data;
                iss++;
            end
            if (vld_e && res_ready) begin
                void'(exp_q.pop_front());
                void'(exp_last_q.pop_front());
                void'(exp_avail_q.pop_front());
                pops++;
            end
            if (start && idle) begin
                if (len == '0) begin
                    done_next = 1'b1;
                end else begin
                    job_active = 1'b1;
                    job_len    = int'(len);
                    iss        = 0;
                    pops       = 0;
                end
            end
            done_now = done_next;
        end
    end

    // stream drivers
    int wv_pct = 0;
    int dv_pct = 0;
    int rr_pct = 0;
    bit d_toggle = 1'b0;

    initial begin
        w_valid = 1'b0; d_valid = 1'b0; res_ready = 1'b0; w_data = '0; d_data = '0;
        forever begin
            @(posedge clk); #1;
            w_data = WW'($urandom);
            for (int i = 0; i < DV_W / 32; i++) d_data[i*32 +: 32] = $urandom;
            w_valid   = (int'($urandom_range(99)) < wv_pct);
            d_valid   = d_toggle ? ~d_valid : (int'($urandom_range(99)) < dv_pct);
            res_ready = (int'($urandom_range(99)) < rr_pct);
        end
    end

    task automatic start_job(input int l);
        @(posedge clk); #1;
        start = 1'b1;
        len   = LW'(l);
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        bit got = 1'b0;
        for (int i = 0; i < budget && !got; i++) begin
            @(negedge clk);
            if (done) got = 1'b1;
        end
        check_eq(tag, got, 1'b1);
    endtask

    task automatic set_streams(input int wv, input int dv, input int rr);
        wv_pct = wv;
        dv_pct = dv;
        rr_pct = rr;
    endtask

    initial begin : main
        int hs0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_eq("rst_res_data", res_data, '0);
        check_eq("rst_res_last", res_last, 1'b0);
        check_eq("rst_state", dbg_state, 2'd0);

        // streaming
        set_streams(100, 100, 100);
        hs0 = hs_cnt;
        start_job(8);
        wait_done("stream_done", 60);
        check_eq("stream_issues", hs_cnt - hs0, 8);

        // zero length
        hs0 = hs_cnt;
        start_job(0);
        wait_done("zero_done", 3);
        check_eq("zero_issues", hs_cnt - hs0, 0);

        // output backpressure
        set_streams(100, 100, 0);
        hs0 = hs_cnt;
        start_job(10);
        repeat (15) @(posedge clk);
        #1;
        check_eq("bp_issues_stalled", hs_cnt - hs0, DEPTH);
        rr_pct = 100;
        wait_done("bp_done", 100);
        check_eq("bp_issues", hs_cnt - hs0, 10);

        // joint handshake with d_valid toggling
        set_streams(100, 0, 100);
        d_toggle = 1'b1;
        hs0 = hs_cnt;
        start_job(6);
        wait_done("joint_done", 80);
        check_eq("joint_issues", hs_cnt - hs0, 6);
        d_toggle = 1'b0;

        // reset mid-job, then a fresh short job
        set_streams(100, 100, 50);
        hs0 = hs_cnt;
        start_job(6);
        for (int i = 0; i < 60 && (hs_cnt - hs0) < 3; i++) @(negedge clk);
        check_eq("rst_third_issue", ((hs_cnt - hs0) >= 3), 1'b1);
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check_eq("midrst_res_valid", res_valid, 1'b0);
        check_eq("midrst_busy", busy, 1'b0);
        check_eq("midrst_eng_w", eng_bus.common_weight_in, '0);
        check_eq("midrst_eng_d", eng_bus.data_in, '0);
        hs0 = hs_cnt;
        start_job(2);
        wait_done("after_rst_done", 40);
        check_eq("after_rst_issues", hs_cnt - hs0, 2);

        // start while busy is ignored
        set_streams(100, 100, 100);
        hs0 = hs_cnt;
        start_job(5);
        @(posedge clk); #1;
        start = 1'b1;
        len   = LW'(9);
        @(posedge clk); #1;
        start = 1'b0;
        wait_done("busy_start_done", 60);
        check_eq("busy_start_issues", hs_cnt - hs0, 5);

        // random jobs
        for (int j = 0; j < 8; j++) begin
            int l;
            set_streams(int'($urandom_range(100, 30)), int'($urandom_range(100, 30)),
                        int'($urandom_range(100, 20)));
            l   = int'($urandom_range(20, 1));
            hs0 = hs_cnt;
            start_job(l);
            wait_done("rand_done", 600);
            check_eq("rand_issues", hs_cnt - hs0, l);
        end

        // maximum length, no counter wrap
        set_streams(100, 100, 80);
        hs0 = hs_cnt;
        start_job(255);
        wait_done("max_len_done", 2000);
        check_eq("max_len_issues", hs_cnt - hs0, 255);

        repeat (3) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
